// File: rtl/ir_queue.sv
// Instruction queue between ifu and exu: DEPTH-entry FIFO of {pc, ir, rv32}.
// Optional IR_QUEUE_BYPASS_EN: zero-latency ifu->exu forwarding when the queue is empty.
module ir_queue #(
  parameter int DEPTH   = 2,
  parameter int XLEN    = 32,
  parameter int PC_SIZE = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [XLEN-1:0]              ifu_q_i_ir,
  input  logic [PC_SIZE-1:0]           ifu_q_i_pc,
  input  logic                         ifu_q_i_valid,
  output logic                         q_ifu_o_ready,
  output logic [XLEN-1:0]              q_exu_o_ir,
  output logic [PC_SIZE-1:0]           q_exu_o_pc,
  output logic                         q_exu_o_rv32,
  output logic                         q_exu_o_valid,
  input  logic                         exu_q_i_ready,
  input  logic                         exu_q_i_flush,
  output logic [$clog2(DEPTH+1)-1:0]   q_o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  function automatic logic is_rv32(input logic [XLEN-1:0] ir);
    return (ir[1:0] == 2'b11) && (ir[4:2] != 3'b111);
  endfunction

  logic [XLEN-1:0]    ir_mem_q   [DEPTH];
  logic [PC_SIZE-1:0] pc_mem_q   [DEPTH];
  logic               rv32_mem_q [DEPTH];

  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [XLEN-1:0]    hold_ir_q, hold_ir_d;
  logic [PC_SIZE-1:0] hold_pc_q, hold_pc_d;
  logic               hold_rv32_q, hold_rv32_d;
  logic               push, pop, not_empty;
`ifdef IR_QUEUE_BYPASS_EN
  logic               byp;
`endif

  always_comb begin
    not_empty     = (count_q != '0);
    q_ifu_o_ready = (count_q != CW'(DEPTH));
    // Empty queue shows whatever exu last saw, so the head never glitches to stale storage.
    q_exu_o_ir    = hold_ir_q;
    q_exu_o_pc    = hold_pc_q;
    q_exu_o_rv32  = hold_rv32_q;
    q_exu_o_valid = not_empty;
    if (not_empty) begin
      q_exu_o_ir   = ir_mem_q[rd_ptr_q];
      q_exu_o_pc   = pc_mem_q[rd_ptr_q];
      q_exu_o_rv32 = rv32_mem_q[rd_ptr_q];
    end
    pop  = not_empty & exu_q_i_ready & ~exu_q_i_flush;
    push = ifu_q_i_valid & q_ifu_o_ready & ~exu_q_i_flush;
`ifdef IR_QUEUE_BYPASS_EN
    byp = ~not_empty & ifu_q_i_valid & ~exu_q_i_flush;
    if (byp) begin
      q_exu_o_ir    = ifu_q_i_ir;
      q_exu_o_pc    = ifu_q_i_pc;
      q_exu_o_rv32  = is_rv32(ifu_q_i_ir);
      q_exu_o_valid = 1'b1;
    end
    // A forwarded instruction taken by exu in the same cycle never enters storage.
    push = push & ~(byp & exu_q_i_ready);
`endif
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
    if (exu_q_i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
    hold_ir_d   = hold_ir_q;
    hold_pc_d   = hold_pc_q;
    hold_rv32_d = hold_rv32_q;
    if (q_exu_o_valid) begin
      hold_ir_d   = q_exu_o_ir;
      hold_pc_d   = q_exu_o_pc;
      hold_rv32_d = q_exu_o_rv32;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      hold_ir_q   <= '0;
      hold_pc_q   <= '0;
      hold_rv32_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      hold_ir_q   <= hold_ir_d;
      hold_pc_q   <= hold_pc_d;
      hold_rv32_q <= hold_rv32_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      ir_mem_q[wr_ptr_q]   <= ifu_q_i_ir;
      pc_mem_q[wr_ptr_q]   <= ifu_q_i_pc;
      rv32_mem_q[wr_ptr_q] <= is_rv32(ifu_q_i_ir);
    end
  end

  assign q_o_count = count_q;

endmodule
